instruction_loader: RTL

Program loader that fills the instruction memory of the MIPS core from a byte stream (the debug UART receive path). It assembles four incoming bytes, most significant first, into one 32-bit instruction word. Each word is written to consecutive byte addresses 0, 4, 8, … on the instruction memory write port. Loading stops at the halt word 32'hFFFF_FFFF or when the memory is full.

---
 rtl/instruction_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// ----------------------------------------------------------------------------
// instruction_loader
//
// Fills the MIPS instruction memory from a byte stream (debug UART receive
// path). Four bytes, most significant first, form one instruction word, which
// is written to byte addresses 0, 4, 8, ... Loading ends after the halt word
// has been written, or with an overflow flag when the last memory word has
// been written without a halt word.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_reset_n      asynchronous active-low reset
//   i_start        begin a new load (honored in IDLE, DONE and ERROR only)
//   i_byte_valid   i_byte carries a valid byte
//   i_byte         program byte, big-endian within a word
//   o_byte_ready   loader accepts a byte this cycle
//   o_wr_en        instruction memory write strobe, one cycle per word
//   o_wr_addr      byte address of the word being written
//   o_wr_data      assembled instruction word
//   o_busy         load in progress (RECV or WRITE)
//   o_done         halt word written, sticky until the next i_start
//   o_overflow     memory full without halt word, sticky until next i_start
//   o_word_count   words written in the current load
// ----------------------------------------------------------------------------
module instruction_loader #(
  parameter int               NBITS     = 32,
  parameter int               CELDAS    = 60,
  parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  output logic             o_byte_ready,
  output logic             o_wr_en,
  output logic [NBITS-1:0] o_wr_addr,
  output logic [NBITS-1:0] o_wr_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic [NBITS-1:0] o_word_count
);

  localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - 4);
  localparam logic [NBITS-1:0] ADDR_STEP = NBITS'(4);
  localparam logic [NBITS-1:0] ONE       = NBITS'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic [NBITS-1:0] word_count_q, word_count_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             start_ok;

  // A byte is only taken in RECV; since ready is decoded from the state,
  // acceptance never depends on anything but the state and i_byte_valid.
  assign accept   = (state_q == RECV) && i_byte_valid;
  assign start_ok = i_start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));

  // State register plus the datapath registers that travel with it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      word_count_q <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state and datapath update. A restart from IDLE/DONE/ERROR clears the
  // whole load context; WRITE decides between halt, overflow and next word,
  // with the halt word taking priority over a full memory.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    done_d       = done_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_ok) begin
          state_d      = RECV;
          shift_d      = '0;
          byte_cnt_d   = '0;
          addr_d       = '0;
          word_count_d = '0;
          done_d       = 1'b0;
          overflow_d   = 1'b0;
        end
      end
      RECV: begin
        if (accept) begin
          shift_d    = {shift_q[NBITS-9:0], i_byte};
          // The 2-bit counter wraps to 0 on the fourth byte by itself.
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        word_count_d = word_count_q + ONE;
        if (shift_q == HALT_WORD) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          state_d    = ERROR;
          overflow_d = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_STEP;
          state_d = RECV;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: strobes come from the state register, data and flags
  // straight from flops, so no input reaches an output combinationally.
  always_comb begin
    o_byte_ready = (state_q == RECV);
    o_wr_en      = (state_q == WRITE);
    o_busy       = (state_q == RECV) || (state_q == WRITE);
    o_wr_addr    = addr_q;
    o_wr_data    = shift_q;
    o_done       = done_q;
    o_overflow   = overflow_q;
    o_word_count = word_count_q;
  end

endmodule
